// File: rtl/vending_core.sv
// Vending machine controller: coin credit, item vend with stock tracking,
// greedy change payout over a ready/valid dispenser handshake.
module vending_core #(
    parameter int unsigned                    N_ITEMS    = 4,
    parameter int unsigned                    CREDIT_W   = 8,
    parameter int unsigned                    STOCK_W    = 4,
    parameter logic [N_ITEMS*CREDIT_W-1:0]    PRICES     = {8'd100, 8'd55, 8'd30, 8'd15},
    parameter int unsigned                    MAX_CREDIT = 200
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 coin_valid,
    input  logic [1:0]           coin_sel,
    input  logic [N_ITEMS-1:0]   item_req,
    input  logic                 cancel,
    input  logic                 refill_valid,
    input  logic [2:0]           refill_item,
    input  logic                 change_ready,
    output logic [CREDIT_W-1:0]  credit,
    output logic                 coin_reject,
    output logic                 vend_valid,
    output logic [2:0]           vend_item,
    output logic                 deny,
    output logic                 change_valid,
    output logic [1:0]           change_coin,
    output logic [N_ITEMS-1:0]   item_avail,
    output logic                 busy
);

    localparam int unsigned AW = CREDIT_W + 1;
    localparam int unsigned IW = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1;
    localparam logic [STOCK_W-1:0] STOCK_FULL = '1;
    localparam logic [AW-1:0]      MAX_W      = AW'(MAX_CREDIT);

    typedef enum logic [1:0] {IDLE, CREDIT, VEND, CHANGE} state_t;

    state_t                state, state_nxt;
    logic [CREDIT_W-1:0]   credit_nxt;
    logic [STOCK_W-1:0]    stock     [N_ITEMS];
    logic [STOCK_W-1:0]    stock_nxt [N_ITEMS];
    logic                  reject_nxt, vend_nxt, deny_nxt, busy_nxt, chg_valid_nxt;
    logic [2:0]            vend_item_nxt;
    logic [1:0]            chg_coin_nxt;
    logic [N_ITEMS-1:0]    avail_nxt;
    logic [IW-1:0]         sel;
    logic [AW-1:0]         credit_w, price_w, coin_sum, change_left;

    function automatic logic [AW-1:0] coin_value(input logic [1:0] c);
        case (c)
            2'd0:    return AW'(1);
            2'd1:    return AW'(5);
            2'd2:    return AW'(10);
            default: return AW'(50);
        endcase
    endfunction

    // Largest coin not exceeding the remaining credit.
    function automatic logic [1:0] greedy_coin(input logic [CREDIT_W-1:0] c);
        logic [AW-1:0] cw;
        cw = {1'b0, c};
        if (cw >= AW'(50))      return 2'd3;
        else if (cw >= AW'(10)) return 2'd2;
        else if (cw >= AW'(5))  return 2'd1;
        else                    return 2'd0;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            credit       <= '0;
            for (int i = 0; i < int'(N_ITEMS); i++) stock[i] <= STOCK_FULL;
            coin_reject  <= 1'b0;
            vend_valid   <= 1'b0;
            vend_item    <= '0;
            deny         <= 1'b0;
            change_valid <= 1'b0;
            change_coin  <= '0;
            item_avail   <= '1;
            busy         <= 1'b0;
        end else begin
            state        <= state_nxt;
            credit       <= credit_nxt;
            stock        <= stock_nxt;
            coin_reject  <= reject_nxt;
            vend_valid   <= vend_nxt;
            vend_item    <= vend_item_nxt;
            deny         <= deny_nxt;
            change_valid <= chg_valid_nxt;
            change_coin  <= chg_coin_nxt;
            item_avail   <= avail_nxt;
            busy         <= busy_nxt;
        end
    end

    // Next state, credit, stock and registered-output values.
    always_comb begin
        state_nxt     = state;
        credit_nxt    = credit;
        stock_nxt     = stock;
        reject_nxt    = 1'b0;
        vend_nxt      = 1'b0;
        vend_item_nxt = '0;
        deny_nxt      = 1'b0;
        sel           = '0;
        price_w       = '0;
        credit_w      = {1'b0, credit};
        coin_sum      = credit_w + coin_value(coin_sel);
        change_left   = credit_w - coin_value(change_coin);

        for (int i = int'(N_ITEMS) - 1; i >= 0; i--) begin
            if (item_req[i]) sel = IW'(i);
        end
        for (int i = 0; i < int'(N_ITEMS); i++) begin
            if (IW'(i) == sel) price_w = {1'b0, PRICES[i*CREDIT_W +: CREDIT_W]};
        end

        case (state)
            IDLE, CREDIT: begin
                if (cancel && state == CREDIT) begin
                    state_nxt  = CHANGE;
                    reject_nxt = coin_valid;
                end else if (|item_req) begin
                    reject_nxt = coin_valid;
                    if (state == CREDIT && stock[sel] != '0 && credit_w >= price_w) begin
                        state_nxt      = VEND;
                        credit_nxt     = CREDIT_W'(credit_w - price_w);
                        stock_nxt[sel] = stock[sel] - STOCK_W'(1);
                        vend_nxt       = 1'b1;
                        vend_item_nxt  = 3'(sel);
                    end else begin
                        deny_nxt = 1'b1;
                    end
                end else if (coin_valid) begin
                    if (coin_sum <= MAX_W) begin
                        credit_nxt = CREDIT_W'(coin_sum);
                        state_nxt  = CREDIT;
                    end else begin
                        reject_nxt = 1'b1;
                    end
                end
            end
            VEND: begin
                reject_nxt = coin_valid;
                state_nxt  = (credit != '0) ? CHANGE : IDLE;
            end
            CHANGE: begin
                reject_nxt = coin_valid;
                if (change_valid && change_ready) begin
                    credit_nxt = CREDIT_W'(change_left);
                    if (change_left == '0) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Refill wins over a same-cycle vend of the same item.
        if (refill_valid && 32'(refill_item) < N_ITEMS) begin
            stock_nxt[refill_item[IW-1:0]] = STOCK_FULL;
        end

        for (int i = 0; i < int'(N_ITEMS); i++) avail_nxt[i] = (stock_nxt[i] != '0);
        busy_nxt      = (state_nxt == VEND) || (state_nxt == CHANGE);
        chg_valid_nxt = (state_nxt == CHANGE);
        chg_coin_nxt  = (state_nxt == CHANGE) ? greedy_coin(credit_nxt) : 2'd0;
    end

endmodule

// File: tb/tb_vending_core.sv
// Scoreboard bench for vending_core: directed scenarios plus random traffic
// checked against an arithmetic model of credit, stock and change.
module tb_vending_core;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       coin_valid = 1'b0;
    logic [1:0] coin_sel = '0;
    logic [3:0] item_req = '0;
    logic       cancel = 1'b0;
    logic       refill_valid = 1'b0;
    logic [2:0] refill_item = '0;
    logic       change_ready = 1'b0;
    logic [7:0] credit;
    logic       coin_reject, vend_valid, deny, change_valid, busy;
    logic [2:0] vend_item;
    logic [1:0] change_coin;
    logic [3:0] item_avail;

    vending_core dut (
        .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin_sel(coin_sel),
        .item_req(item_req), .cancel(cancel), .refill_valid(refill_valid),
        .refill_item(refill_item), .change_ready(change_ready), .credit(credit),
        .coin_reject(coin_reject), .vend_valid(vend_valid), .vend_item(vend_item),
        .deny(deny), .change_valid(change_valid), .change_coin(change_coin),
        .item_avail(item_avail), .busy(busy)
    );

    always #5 clk = ~clk;

    localparam int EV_REJ = 0, EV_VEND = 1, EV_DENY = 2, EV_CHG = 3;
    typedef struct {int kind; int arg; int cred;} ev_t;
    ev_t sbq[$];

    int coin_val[4] = '{1, 5, 10, 50};
    int price[4]    = '{15, 30, 55, 100};
    int tests = 0, fails = 0;

    // reference model: credit in units, stock counts, and two activity flags
    int   m_credit;
    bit   m_vend, m_change;
    int   m_stock[4];
    int   s_credit, s_coin_val;
    bit   s_busy, s_chg, s_valid = 1'b0;
    logic [3:0] s_avail;

    task automatic chk(string name, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int greedy(int c);
        if (c >= 50) return 50;
        if (c >= 10) return 10;
        if (c >= 5)  return 5;
        if (c >= 1)  return 1;
        return 0;
    endfunction

    task automatic push(int k, int a, int c);
        ev_t e;
        e.kind = k; e.arg = a; e.cred = c;
        sbq.push_back(e);
    endtask

    task automatic model_reset();
        m_credit = 0; m_vend = 0; m_change = 0;
        for (int i = 0; i < 4; i++) m_stock[i] = 15;
        sbq.delete();
        s_valid = 0;
    endtask

    // Drive one cycle of inputs, advance the model, queue expected responses.
    task automatic step(bit cv, logic [1:0] cs, logic [3:0] req, bit cn,
                        bit rv, logic [2:0] ri, bit cr);
        int  c;
        bit  rej, dn, vd;
        int  vi;
        coin_valid = cv; coin_sel = cs; item_req = req; cancel = cn;
        refill_valid = rv; refill_item = ri; change_ready = cr;
        s_credit = m_credit; s_busy = m_vend || m_change; s_chg = m_change;
        s_coin_val = greedy(m_credit);
        for (int i = 0; i < 4; i++) s_avail[i] = (m_stock[i] > 0);
        s_valid = 1;
        c = m_credit; rej = 0; dn = 0; vd = 0; vi = 0;
        if (m_vend) begin
            m_vend = 0; m_change = (c > 0); rej = cv;
        end else if (m_change) begin
            rej = cv;
            if (cr) begin
                int g;
                g = greedy(c);
                push(EV_CHG, g, c);
                c -= g;
                if (c == 0) m_change = 0;
            end
        end else begin
            if (cn && c > 0) begin
                m_change = 1; rej = cv;
            end else if (req != 0) begin
                int i;
                i = 0;
                while (!req[i]) i++;
                rej = cv;
                if (c > 0 && m_stock[i] > 0 && c >= price[i]) begin
                    c -= price[i]; m_stock[i]--; m_vend = 1; vd = 1; vi = i;
                end else dn = 1;
            end else if (cv) begin
                if (c + coin_val[cs] <= 200) c += coin_val[cs];
                else rej = 1;
            end
        end
        if (rv && ri < 4) m_stock[ri] = 15;
        m_credit = c;
        if (rej) push(EV_REJ, 0, c);
        if (vd)  push(EV_VEND, vi, c);
        if (dn)  push(EV_DENY, 0, c);
        @(posedge clk);
        #1;
    endtask

    task automatic coin(logic [1:0] s);   step(1, s, 0, 0, 0, 0, 0);    endtask
    task automatic buy(logic [3:0] m);    step(0, 0, m, 0, 0, 0, 0);    endtask
    task automatic idle(bit cr);          step(0, 0, 0, 0, 0, 0, cr);   endtask

    task automatic drain();
        for (int k = 0; k < 200 && (m_vend || m_change); k++) idle(1);
        chk("drain_busy", busy, 0);
    endtask

    task automatic expect_ev(int kind, int arg);
        ev_t e;
        tests++;
        if (sbq.size() == 0) begin
            fails++;
            $display("FAIL sb_unexpected: got event kind %0d arg %0d expected none", kind, arg);
        end else begin
            tests--;
            e = sbq.pop_front();
            chk("sb_kind", kind, e.kind);
            chk("sb_arg", arg, e.arg);
            chk("sb_credit", credit, e.cred);
        end
    endtask

    // Monitor: per-cycle state compare and scoreboard pops on DUT responses.
    always @(negedge clk) begin
        if (!rst && s_valid) begin
            chk("credit", credit, s_credit);
            chk("busy", busy, s_busy);
            chk("item_avail", item_avail, s_avail);
            chk("change_valid", change_valid, s_chg);
            if (s_chg) chk("change_coin", coin_val[change_coin], s_coin_val);
            if (coin_reject) expect_ev(EV_REJ, 0);
            if (vend_valid)  expect_ev(EV_VEND, vend_item);
            if (deny)        expect_ev(EV_DENY, 0);
            if (change_valid && change_ready) expect_ev(EV_CHG, coin_val[change_coin]);
        end
    end

    task automatic check_reset_outputs(string tag);
        chk({tag, "_credit"}, credit, 0);
        chk({tag, "_pulses"}, {coin_reject, vend_valid, deny}, 0);
        chk({tag, "_change_valid"}, change_valid, 0);
        chk({tag, "_change_coin"}, change_coin, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_item_avail"}, item_avail, 4'hF);
    endtask

    initial begin
        int exp43[5] = '{10, 10, 10, 10, 5};
        int exp44[7] = '{50, 50, 50, 10, 10, 10, 10};
        model_reset();
        #2 rst = 1'b1;
        #1 check_reset_outputs("reset");
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // three 10s then item 1 at exactly its price
        repeat (3) coin(2);
        chk("r42_credit30", credit, 30);
        buy(4'b0010);
        chk("r42_vend", vend_valid, 1);
        chk("r42_item", vend_item, 1);
        chk("r42_credit0", credit, 0);
        idle(0);
        chk("r42_idle_busy", busy, 0);
        chk("r42_no_change", change_valid, 0);

        // vend item 0 from 60, then 45 in change
        coin(3); coin(2);
        buy(4'b0001);
        chk("r43_item", vend_item, 0);
        chk("r43_credit45", credit, 45);
        idle(1);
        for (int j = 0; j < 5; j++) begin
            chk("r43_coin", change_valid ? coin_val[change_coin] : -1, exp43[j]);
            idle(1);
        end
        chk("r43_done_valid", change_valid, 0);
        chk("r43_done_credit", credit, 0);

        // ceiling reject at 190, then full refund
        repeat (3) coin(3);
        repeat (4) coin(2);
        chk("r44_credit190", credit, 190);
        coin(3);
        chk("r44_reject", coin_reject, 1);
        chk("r44_credit_kept", credit, 190);
        step(0, 0, 0, 1, 0, 0, 0);
        for (int j = 0; j < 7; j++) begin
            chk("r44_coin", change_valid ? coin_val[change_coin] : -1, exp44[j]);
            idle(1);
        end
        chk("r44_credit0", credit, 0);

        // sell out item 0, deny, refill
        step(0, 0, 0, 0, 1, 0, 0);
        for (int j = 0; j < 15; j++) begin
            coin(2); coin(1); buy(4'b0001); idle(0);
        end
        chk("r45_avail0_low", item_avail[0], 0);
        coin(2); coin(1); buy(4'b0001);
        chk("r45_deny", deny, 1);
        chk("r45_credit15", credit, 15);
        step(0, 0, 0, 0, 1, 0, 0);
        chk("r45_avail0_high", item_avail[0], 1);
        step(0, 0, 0, 1, 0, 0, 0);
        drain();

        // deny on insufficient credit; coin+cancel same cycle
        coin(1);
        buy(4'b1000);
        chk("r46_deny", deny, 1);
        chk("r46_credit5", credit, 5);
        step(1, 0, 0, 1, 0, 0, 0);
        chk("r46_reject", coin_reject, 1);
        chk("r46_change", change_valid, 1);
        chk("r46_credit_kept", credit, 5);
        drain();

        // stalled dispenser, then reset mid-change
        coin(3); coin(2);
        step(0, 0, 0, 1, 0, 0, 0);
        for (int j = 0; j < 5; j++) begin
            chk("r47_coin_stable", change_coin, 3);
            chk("r47_credit_stable", credit, 60);
            idle(0);
        end
        #2 rst = 1'b1;
        #1 check_reset_outputs("r47_midreset");
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        idle(0);
        chk("r47_after_change", change_valid, 0);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 2) == 0, 2'($urandom),
                 ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'h0,
                 $urandom_range(0, 15) == 0, $urandom_range(0, 19) == 0,
                 3'($urandom), 1'($urandom));
        end
        drain();
        idle(0);
        idle(0);
        chk("sb_empty", sbq.size(), 0);
        s_valid = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
